// File: rtl/uart_slot_router_pkg.sv
// Shared definitions for the MCU UART slot router: SPI command code and FSM state encoding.
// No logic lives here.
package uart_slot_router_pkg;

  localparam logic [15:0] C_SET_UART_SLOT = 16'h0031;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUIET  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_line_sync.sv
// 2-FF synchroniser for a UART line, preset to mark; anything but a clean 0 reads as 1.
// Latency 2 clk, no backpressure.
module uart_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic w_d;
  logic r_meta;
  logic r_sync;

  // An undriven shared bus (z/x) must look like an idle line.
  assign w_d = (i_d === 1'b0) ? 1'b0 : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= w_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_slot_router.sv
// Routes the MCU UART to one slot card; slot switches wait for a guard time of idle on both lines.
// Passthrough latency 3 clk; no backpressure, SPI requests overwrite any pending one.
module uart_slot_router
  import uart_slot_router_pkg::*;
#(
  parameter int UART_ADDRESS_WIDTH = 3,
  parameter int GUARD_CYCLES       = 1000,
  parameter int SETTLE_CYCLES      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   spi_cmd_r,
  input  logic [7:0]                    spi_addr_r,
  input  logic [39:0]                   spi_data_r,
  input  logic                          spi_data_valid_r,
  input  logic                          mcu_uart_tx,
  output logic                          mcu_uart_rx,
  input  logic                          rx_slot,
  output logic                          tx_slot,
  output logic [UART_ADDRESS_WIDTH-1:0] uart_slot_en,
  output logic                          switch_busy
);

  localparam int AW = UART_ADDRESS_WIDTH;
  localparam int CW = $clog2(GUARD_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_MAX   = CW'(GUARD_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t          r_state, w_state_nxt;
  logic            r_pend, w_pend_nxt;
  logic [AW-1:0]   r_pend_slot, w_pend_slot_nxt;
  logic [CW-1:0]   r_idle_cnt, w_idle_cnt_nxt;
  logic [SW-1:0]   r_settle_cnt, w_settle_cnt_nxt;
  logic [AW-1:0]   r_slot_en, w_slot_en_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_rx, w_rx_nxt;

  logic            w_tx_sync;
  logic            w_rx_sync;
  logic            w_req;
  logic [AW-1:0]   w_req_slot;
  logic            w_want;
  logic [AW-1:0]   w_target;
  logic            w_lines_idle;
  logic            w_unused_ok;

  uart_line_sync u_tx_sync (.clk(clk), .reset(reset), .i_d(mcu_uart_tx), .o_q(w_tx_sync));
  uart_line_sync u_rx_sync (.clk(clk), .reset(reset), .i_d(rx_slot),     .o_q(w_rx_sync));

  assign w_req        = spi_data_valid_r && (spi_cmd_r == C_SET_UART_SLOT);
  assign w_req_slot   = spi_data_r[AW-1:0];
  // A request on this very cycle takes precedence over one latched earlier.
  assign w_want       = w_req | r_pend;
  assign w_target     = w_req ? w_req_slot : r_pend_slot;
  assign w_lines_idle = w_tx_sync & w_rx_sync;
  assign w_unused_ok  = ^{spi_addr_r, spi_data_r[39:AW]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pend_nxt       = r_pend;
    w_pend_slot_nxt  = r_pend_slot;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_slot_en_nxt    = r_slot_en;
    w_busy_nxt       = r_busy;
    w_tx_nxt         = w_tx_sync;
    w_rx_nxt         = (r_slot_en == '0) ? 1'b1 : w_rx_sync;

    if (w_req) begin
      w_pend_nxt      = 1'b1;
      w_pend_slot_nxt = w_req_slot;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_want) begin
          if (w_target == r_slot_en) begin
            w_pend_nxt = 1'b0;
          end else begin
            w_state_nxt    = ST_QUIET;
            w_busy_nxt     = 1'b1;
            w_idle_cnt_nxt = '0;
          end
        end
      end
      ST_QUIET: begin
        if (w_req || !w_lines_idle) begin
          w_idle_cnt_nxt = '0;
        end else begin
          if (r_idle_cnt >= GUARD_LAST) w_state_nxt = ST_SWITCH;
          if (r_idle_cnt != GUARD_MAX)  w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      ST_SWITCH: begin
        w_slot_en_nxt    = r_pend_slot;
        if (!w_req) w_pend_nxt = 1'b0;
        w_tx_nxt         = 1'b1;
        w_rx_nxt         = 1'b1;
        w_settle_cnt_nxt = '0;
        w_state_nxt      = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_tx_nxt = 1'b1;
        w_rx_nxt = 1'b1;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend       <= 1'b0;
      r_pend_slot  <= '0;
      r_idle_cnt   <= '0;
      r_settle_cnt <= '0;
      r_slot_en    <= '0;
      r_busy       <= 1'b0;
      r_tx         <= 1'b1;
      r_rx         <= 1'b1;
    end else begin
      r_pend       <= w_pend_nxt;
      r_pend_slot  <= w_pend_slot_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_slot_en    <= w_slot_en_nxt;
      r_busy       <= w_busy_nxt;
      r_tx         <= w_tx_nxt;
      r_rx         <= w_rx_nxt;
    end
  end

  assign tx_slot      = r_tx;
  assign mcu_uart_rx  = r_rx;
  assign uart_slot_en = r_slot_en;
  assign switch_busy  = r_busy;

endmodule

// File: tb/tb_uart_slot_router.sv
// Scenario bench for uart_slot_router: passthrough scoreboard, guard timing, overwrite, reset.
module tb_uart_slot_router;
  import uart_slot_router_pkg::*;

  localparam int AW     = 3;
  localparam int GUARD  = 20;
  localparam int SETTLE = 4;
  localparam int BITLEN = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   spi_cmd_r;
  logic [7:0]    spi_addr_r;
  logic [39:0]   spi_data_r;
  logic          spi_data_valid_r;
  logic          mcu_uart_tx;
  logic          rx_slot;
  wire           mcu_uart_rx;
  wire           tx_slot;
  wire [AW-1:0]  uart_slot_en;
  wire           switch_busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic q_tx[$];
  logic q_rx[$];
  bit   track5 = 1'b0;
  bit   seen5  = 1'b0;

  uart_slot_router #(
    .UART_ADDRESS_WIDTH(AW), .GUARD_CYCLES(GUARD), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .spi_cmd_r(spi_cmd_r), .spi_addr_r(spi_addr_r),
    .spi_data_r(spi_data_r), .spi_data_valid_r(spi_data_valid_r),
    .mcu_uart_tx(mcu_uart_tx), .mcu_uart_rx(mcu_uart_rx), .rx_slot(rx_slot),
    .tx_slot(tx_slot), .uart_slot_en(uart_slot_en), .switch_busy(switch_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (track5 && uart_slot_en == 3'd5) seen5 = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one SPI strobe across a single clock edge; upper payload bits are random junk.
  task automatic strobe(input logic [15:0] cmd, input logic [AW-1:0] slot);
    spi_cmd_r        = cmd;
    spi_addr_r       = 8'($urandom);
    spi_data_r       = {8'hA5, 32'($urandom)};
    spi_data_r[AW-1:0] = slot;
    spi_data_valid_r = 1'b1;
    tick();
    spi_data_valid_r = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mcu_uart_tx = 1'b0; rx_slot = 1'bz;
    spi_cmd_r = '0; spi_addr_r = '0; spi_data_r = '0; spi_data_valid_r = 1'b0;
    repeat (3) tick();
    n_tests++; if (uart_slot_en !== 3'd0) begin n_fail++; $display("FAIL reset_slot_en: got %0d want 0", uart_slot_en); end
    n_tests++; if (tx_slot !== 1'b1) begin n_fail++; $display("FAIL reset_tx_slot: got %b want 1", tx_slot); end
    n_tests++; if (mcu_uart_rx !== 1'b1) begin n_fail++; $display("FAIL reset_mcu_rx: got %b want 1", mcu_uart_rx); end
    n_tests++; if (switch_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", switch_busy); end
    mcu_uart_tx = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_passthrough();
    logic [15:0] pat = 16'hD271;
    logic        v;
    logic        exp;
    q_tx.delete();
    for (int i = 0; i < 35; i++) begin
      v = (i >= 32) ? 1'b1 : (i < 16) ? pat[i] : 1'($urandom_range(0, 1));
      mcu_uart_tx = v;
      q_tx.push_back(v);
      tick();
      if (q_tx.size() == 3) begin
        exp = q_tx.pop_front();
        n_tests++; if (tx_slot !== exp) begin n_fail++; $display("FAIL pass_tx step %0d: got %b want %b", i, tx_slot, exp); end
        n_tests++; if (mcu_uart_rx !== 1'b1) begin n_fail++; $display("FAIL pass_rx_slot0 step %0d: got %b want 1", i, mcu_uart_rx); end
      end
    end
  endtask

  task automatic test_switch();
    rx_slot = 1'b1; mcu_uart_tx = 1'b1;
    repeat (4) tick();
    strobe(C_SET_UART_SLOT, 3'd3);
    n_tests++; if (switch_busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy_rise: got %b want 1", switch_busy); end
    repeat (GUARD) tick();
    n_tests++; if (uart_slot_en !== 3'd0) begin n_fail++; $display("FAIL sw_early: got %0d want 0", uart_slot_en); end
    tick();
    n_tests++; if (uart_slot_en !== 3'd3) begin n_fail++; $display("FAIL sw_slot: got %0d want 3", uart_slot_en); end
    mcu_uart_tx = 1'b0;
    for (int i = 0; i < SETTLE - 1; i++) begin
      tick();
      n_tests++; if ({switch_busy, tx_slot, mcu_uart_rx} !== 3'b111) begin n_fail++; $display("FAIL sw_settle %0d: got %b want 111", i, {switch_busy, tx_slot, mcu_uart_rx}); end
    end
    tick();
    n_tests++; if ({switch_busy, tx_slot} !== 2'b01) begin n_fail++; $display("FAIL sw_busy_fall: got %b want 01", {switch_busy, tx_slot}); end
    tick();
    n_tests++; if (tx_slot !== 1'b0) begin n_fail++; $display("FAIL sw_pass_resume: got %b want 0", tx_slot); end
    mcu_uart_tx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_guard_traffic();
    logic [9:0] frame = {1'b1, 8'h55, 1'b0};
    logic       v;
    logic       exp;
    int         last0 = -100;
    q_rx.delete();
    for (int k = 0; k < 70; k++) begin
      if (k == 0) begin
        spi_cmd_r = C_SET_UART_SLOT; spi_data_r = {8'h3C, 32'($urandom)};
        spi_data_r[AW-1:0] = 3'd5; spi_data_valid_r = 1'b1;
      end else begin
        spi_data_valid_r = 1'b0;
      end
      v = (k < 10 * BITLEN) ? frame[k / BITLEN] : 1'b1;
      if (v == 1'b0) last0 = k;
      rx_slot = v;
      q_rx.push_back(v);
      tick();
      if (k == 0) begin
        n_tests++; if (switch_busy !== 1'b1) begin n_fail++; $display("FAIL gt_busy: got %b want 1", switch_busy); end
      end
      if (q_rx.size() == 3) begin
        exp = q_rx.pop_front();
        n_tests++; if (mcu_uart_rx !== exp) begin n_fail++; $display("FAIL gt_rx_bit step %0d: got %b want %b", k, mcu_uart_rx, exp); end
      end
      // Line goes high at last0+1; 2 synchroniser cycles + GUARD idle counts + 1 switch cycle.
      if (k == last0 + 1 + GUARD + 1) begin
        n_tests++; if (uart_slot_en !== 3'd3) begin n_fail++; $display("FAIL gt_early: got %0d want 3", uart_slot_en); end
      end
      if (k == last0 + 1 + GUARD + 2) begin
        n_tests++; if (uart_slot_en !== 3'd5) begin n_fail++; $display("FAIL gt_switch: got %0d want 5", uart_slot_en); end
      end
    end
    n_tests++; if ({switch_busy, uart_slot_en} !== {1'b0, 3'd5}) begin n_fail++; $display("FAIL gt_done: got %b want 0101", {switch_busy, uart_slot_en}); end
  endtask

  task automatic test_same_slot();
    mcu_uart_tx = 1'b1; rx_slot = 1'b1;
    strobe(C_SET_UART_SLOT ^ 16'h0100, 3'd1);
    strobe(C_SET_UART_SLOT, 3'd5);
    for (int i = 0; i < 30; i++) begin
      n_tests++;
      if ({switch_busy, tx_slot, uart_slot_en} !== {1'b0, 1'b1, 3'd5}) begin
        n_fail++; $display("FAIL same_slot step %0d: got %b want 01101", i, {switch_busy, tx_slot, uart_slot_en});
      end
      tick();
    end
  endtask

  task automatic test_restart();
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    mcu_uart_tx = 1'b1; rx_slot = 1'b1;
    repeat (4) tick();
    seen5 = 1'b0; track5 = 1'b1;
    strobe(C_SET_UART_SLOT, 3'd5);
    repeat (9) tick();
    strobe(C_SET_UART_SLOT, 3'd2);
    repeat (GUARD) tick();
    n_tests++; if (uart_slot_en !== 3'd0) begin n_fail++; $display("FAIL rs_early: got %0d want 0", uart_slot_en); end
    tick();
    n_tests++; if (uart_slot_en !== 3'd2) begin n_fail++; $display("FAIL rs_final: got %0d want 2", uart_slot_en); end
    repeat (SETTLE + 2) tick();
    track5 = 1'b0;
    n_tests++; if (seen5 !== 1'b0) begin n_fail++; $display("FAIL rs_never5: got %b want 0", seen5); end
    n_tests++; if (switch_busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy: got %b want 0", switch_busy); end
  endtask

  task automatic test_reset_in_settle();
    strobe(C_SET_UART_SLOT, 3'd3);
    repeat (GUARD) tick();
    tick();
    n_tests++; if (uart_slot_en !== 3'd3) begin n_fail++; $display("FAIL rst_pre: got %0d want 3", uart_slot_en); end
    strobe(C_SET_UART_SLOT, 3'd6);
    mcu_uart_tx = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if ({uart_slot_en, switch_busy, tx_slot, mcu_uart_rx} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rst_settle: got %b want 000011", {uart_slot_en, switch_busy, tx_slot, mcu_uart_rx});
    end
    reset = 1'b0; mcu_uart_tx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if ({uart_slot_en, switch_busy} !== 4'b0000) begin
        n_fail++; $display("FAIL rst_discard step %0d: got %b want 0000", i, {uart_slot_en, switch_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_switch();
    test_guard_traffic();
    test_same_slot();
    test_restart();
    test_reset_in_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no finish, want finish before 200000ns");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
